// File: rtl/score_bcd_keeper.sv
// Binary score to packed BCD via an iterative double-dabble engine, plus a high-score latch.
// Latency: WIDTH+1 edges from capture (IDLE sees size != conv_src) to score_bcd update.
// Backpressure: none; size changes during a conversion are picked up on the return to IDLE.
//
// Optional feature macro: SCORE_HIGH_SCORE_EN compiles in the high-score latch
// (go/pending/high_bin/high_bcd). When undefined, high_bcd is tied to 0 and iGameover is unused.
//
// Ports:
//   iClock       system clock, single domain
//   iReset       synchronous active-high reset
//   size         live binary score (WIDTH bits)
//   iGameover    level, high while the game is over
//   score_bcd    packed BCD of the last fully converted size, digit 0 in [3:0]
//   high_bcd     packed BCD of the high score
//   busy         high while a conversion is in flight (SHIFT or DONE)
//   score_valid  one-cycle pulse when score_bcd has just been updated
module score_bcd_keeper #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic [WIDTH-1:0]      size,
    input  logic                  iGameover,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic                  busy,
    output logic                  score_valid
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = WIDTH + BW;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] conv_src_q, conv_src_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [SW-1:0]   adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   score_q, score_d;
    logic            valid_q, valid_d;

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        adj = sh_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                adj[WIDTH + 4*i +: 4] = sh_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        conv_src_d = conv_src_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        score_d    = score_q;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (size != conv_src_q) begin
                    sh_d       = {{BW{1'b0}}, size};
                    conv_src_d = size;
                    cnt_d      = '0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_d  = adj << 1;
                cnt_d = cnt_q + CW'(1);
                // The count value WIDTH-1 marks the WIDTH-th shift.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                score_d = sh_q[SW-1 -: BW];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            conv_src_q <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            score_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_src_q <= conv_src_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            valid_q    <= valid_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign score_bcd   = score_q;
    assign score_valid = valid_q;

`ifdef SCORE_HIGH_SCORE_EN
    logic             go_q;
    logic             pend_q;
    logic             commit;
    logic [WIDTH-1:0] high_bin_q;
    logic [BW-1:0]    high_bcd_q;

    // Commit only once the converter has settled on the current size, so
    // score_bcd is known to be the BCD image of conv_src.
    assign commit = pend_q && (state_q == S_IDLE) && (size == conv_src_q);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            go_q       <= 1'b0;
            pend_q     <= 1'b0;
            high_bin_q <= '0;
            high_bcd_q <= '0;
        end else begin
            go_q <= iGameover;
            if (commit) begin
                // A game-over rise landing on the commit edge is absorbed.
                pend_q <= 1'b0;
                if (conv_src_q > high_bin_q) begin
                    high_bin_q <= conv_src_q;
                    high_bcd_q <= score_q;
                end
            end else if (iGameover && !go_q) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign high_bcd = high_bcd_q;
`else
    logic unused_gameover;
    assign unused_gameover = iGameover;
    assign high_bcd        = '0;
`endif

endmodule

// File: tb/tb_score_bcd_keeper.sv
module tb_score_bcd_keeper;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;
    localparam int LAT    = WIDTH + 2;  // steps from driving size to seeing score_valid
`ifdef SCORE_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic                iClock = 1'b0;
    logic                iReset;
    logic [WIDTH-1:0]    size;
    logic                iGameover;
    logic [4*DIGITS-1:0] score_bcd;
    logic [4*DIGITS-1:0] high_bcd;
    logic                busy;
    logic                score_valid;

    int checks = 0;
    int errors = 0;
    int m_high = 0;

    score_bcd_keeper #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .size        (size),
        .iGameover   (iGameover),
        .score_bcd   (score_bcd),
        .high_bcd    (high_bcd),
        .busy        (busy),
        .score_valid (score_valid)
    );

    always #5 iClock = ~iClock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Decimal digits by plain division.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_high();
        return HS_EN ? to_bcd(m_high) : 16'h0000;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iClock);
            #1;
        end
    endtask

    // Drive v and wait (bounded) for the completing score_valid; report latency,
    // the score seen at that point, and how many pulses appear in a short window.
    task automatic run_conv(input logic [WIDTH-1:0] v, output int lat,
                            output logic [15:0] bcd, output int pulses);
        size   = v;
        lat    = 0;
        pulses = 0;
        do begin
            step(1);
            lat++;
        end while (score_valid !== 1'b1 && lat < 100);
        bcd = score_bcd;
        if (score_valid === 1'b1) pulses = 1;
        repeat (3) begin
            step(1);
            if (score_valid === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        int bad;
        iReset = 1'b1; size = '0; iGameover = 1'b0;
        step(3);
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score got %h want 0000", score_bcd); end
        checks++; if (high_bcd !== 16'h0000) begin errors++; $display("FAIL reset_high got %h want 0000", high_bcd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", score_valid); end
        iReset = 1'b0;
        bad = 0;
        repeat (20) begin
            step(1);
            if (busy !== 1'b0 || score_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_zero busy/valid active in %0d cycles want 0", bad); end
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL idle_zero_score got %h want 0000", score_bcd); end
    endtask

    task automatic test_latency();
        int pulses;
        size = 12'd37;
        step(1);  // capture edge
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_rise got %b want 1", busy); end
        pulses = 0;
        repeat (LAT - 2) begin
            step(1);
            if (score_valid === 1'b1) pulses++;
        end
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL lat_early_score got %h want 0000", score_bcd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_done got %b want 1", busy); end
        step(1);  // WIDTH+1 edges after capture
        if (score_valid === 1'b1) pulses++;
        checks++; if (score_bcd !== 16'h0037) begin errors++; $display("FAIL lat_score got %h want 0037", score_bcd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_fall got %b want 0", busy); end
        repeat (4) begin
            step(1);
            if (score_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL lat_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_values();
        int lat, pulses;
        logic [15:0] bcd;
        run_conv(12'd4095, lat, bcd, pulses);
        checks++; if (bcd !== 16'h4095) begin errors++; $display("FAIL val_4095 got %h want 4095", bcd); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL val_4095_lat got %0d want %0d", lat, LAT); end
        run_conv(12'd10, lat, bcd, pulses);
        checks++; if (bcd !== 16'h0010) begin errors++; $display("FAIL val_10 got %h want 0010", bcd); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL val_10_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_change_midshift();
        int t1, t2;
        size = 12'd5;
        step(4);  // capture plus three SHIFT cycles
        size = 12'd9;
        t1 = 4;
        do begin step(1); t1++; end while (score_valid !== 1'b1 && t1 < 100);
        checks++; if (score_bcd !== 16'h0005) begin errors++; $display("FAIL mid_first got %h want 0005", score_bcd); end
        checks++; if (t1 != LAT) begin errors++; $display("FAIL mid_first_lat got %0d want %0d", t1, LAT); end
        t2 = 0;
        do begin step(1); t2++; end while (score_valid !== 1'b1 && t2 < 100);
        checks++; if (score_bcd !== 16'h0009) begin errors++; $display("FAIL mid_second got %h want 0009", score_bcd); end
        checks++; if (t2 != LAT) begin errors++; $display("FAIL mid_b2b_gap got %0d want %0d", t2, LAT); end
        step(3);
    endtask

    task automatic play_game(input int v);
        int lat, pulses;
        logic [15:0] bcd;
        run_conv(WIDTH'(v), lat, bcd, pulses);
        checks++; if (bcd !== to_bcd(v)) begin errors++; $display("FAIL game_score_%0d got %h want %h", v, bcd, to_bcd(v)); end
        iGameover = 1'b1;
        step(2);
        if (v > m_high) m_high = v;
        checks++; if (high_bcd !== exp_high()) begin errors++; $display("FAIL game_high_%0d got %h want %h", v, high_bcd, exp_high()); end
        step(3);
        iGameover = 1'b0;
        step(2);
    endtask

    task automatic test_high_score();
        int t;
        play_game(42);
        play_game(17);
        play_game(100);
        // Game over raised mid-conversion: commit waits for the return to IDLE.
        size = 12'd200;
        step(1);
        iGameover = 1'b1;
        t = 1;
        do begin step(1); t++; end while (score_valid !== 1'b1 && t < 100);
        checks++; if (high_bcd !== exp_high()) begin errors++; $display("FAIL hs_inflight_hold got %h want %h", high_bcd, exp_high()); end
        step(1);
        m_high = 200;
        checks++; if (high_bcd !== exp_high()) begin errors++; $display("FAIL hs_inflight_commit got %h want %h", high_bcd, exp_high()); end
        iGameover = 1'b0;
        step(2);
    endtask

    task automatic test_reset_midshift();
        int lat, pulses;
        logic [15:0] bcd;
        size = 12'd999;
        step(5);
        iReset = 1'b1;
        step(1);
        m_high = 0;
        checks++; if (score_bcd !== 16'h0000 || high_bcd !== 16'h0000 || busy !== 1'b0 || score_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got score=%h high=%h busy=%b valid=%b want all 0", score_bcd, high_bcd, busy, score_valid);
        end
        iReset = 1'b0;
        run_conv(12'd999, lat, bcd, pulses);
        checks++; if (bcd !== 16'h0999) begin errors++; $display("FAIL rst_reconv got %h want 0999", bcd); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL rst_reconv_lat got %0d want %0d", lat, LAT); end
        checks++; if (high_bcd !== 16'h0000) begin errors++; $display("FAIL rst_high got %h want 0000", high_bcd); end
    endtask

    // Random size changes against a latency-based model: a conversion is taken
    // whenever the engine is free and size differs from the last value taken,
    // and its decimal image appears WIDTH+1 edges later.
    task automatic test_random();
        int m_src, m_left, bad;
        logic [15:0] m_score;
        logic m_valid;
        iReset = 1'b1; size = '0;
        step(2);
        iReset = 1'b0;
        m_src = 0; m_left = 0; m_score = 16'h0000;
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) size = WIDTH'($urandom_range(0, 4095));
            step(1);
            m_valid = 1'b0;
            if (m_left == 0) begin
                if (int'(size) != m_src) begin
                    m_src  = int'(size);
                    m_left = WIDTH + 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_score = to_bcd(m_src);
                    m_valid = 1'b1;
                end
            end
            checks++;
            if (score_bcd !== m_score || score_valid !== m_valid || busy !== (m_left != 0)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_cycle_%0d got score=%h valid=%b busy=%b want score=%h valid=%b busy=%b",
                             c, score_bcd, score_valid, busy, m_score, m_valid, (m_left != 0));
            end
        end
    endtask

    initial begin
        iReset = 1'b1;
        size = '0;
        iGameover = 1'b0;
        test_reset();
        test_latency();
        test_values();
        test_change_midshift();
        test_high_score();
        test_reset_midshift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
